led_seq_ctrl: RTL and testbench
===============================

// Module: led_seq_ctrl
// PURPOSE
//  Pattern sequencer for the 4-LED bank: takes debounced single-cycle button pulses (from
//  debouncer_edge_det) and drives mode, speed and run/pause state. Generates step ticks and
//  the registered LED pattern. Sits between the debouncers and the board LEDs in the lab top.
// PARAMETERS
//  CYCLES_PER_UNIT  125_000_000  clk cycles per speed unit (1 s at 125 MHz); bench uses 100
//  SPEED_MAX        3            largest step period, in units; speed cycles 1..SPEED_MAX
// PORTS
//  clk          in   1  system clock, all logic on rising edge
//  rst_n        in   1  asynchronous, active-low reset
//  mode_pulse   in   1  1-cycle pulse: advance to next mode
//  speed_pulse  in   1  1-cycle pulse: advance to next speed
//  pause_pulse  in   1  1-cycle pulse: toggle run/pause
//  leds         out  4  registered LED pattern
//  mode         out  2  current mode (0 bounce, 1 rotate-up, 2 rotate-down, 3 fill)
//  speed_units  out  2  current step period in units (1..SPEED_MAX)
//  running      out  1  1 = stepping, 0 = paused
//  tick         out  1  registered 1-cycle pulse, high in the cycle leds show a new step
// BEHAVIOUR
//  Reset: leds=0001, mode=0, speed_units=1, running=1, tick=0, prescaler=0, pos=0, dir=up.
//  Prescaler: counts 0..CYCLES_PER_UNIT*speed_units-1 while running; width
//   $clog2(CYCLES_PER_UNIT*SPEED_MAX). Terminal count -> wraps to 0 and steps pattern on that edge.
//  Step latency: leds and tick update on the same edge. tick is 0 on every other cycle.
//  Paused: prescaler, pos, dir and leds frozen. tick stays 0.
//  Patterns (pos = step index, starts at 0 on mode entry):
//   mode0 bounce  0001,0010,0100,1000,0100,0010 repeating (period 6). dir flips at pos3 and pos0.
//   mode1 rot-up  0001,0010,0100,1000 repeating.
//   mode2 rot-dn  1000,0100,0010,0001 repeating.
//   mode3 fill    0001,0011,0111,1111,0000 repeating (period 5).
//  mode_pulse: mode <= mode+1 (3 wraps to 0). Restart state: pos=0, dir=up, prescaler=0.
//   leds show the new mode's first pattern on the next edge. No tick. running is unchanged.
//  speed_pulse: speed_units <= speed_units+1, SPEED_MAX wraps to 1. prescaler=0.
//   pos and leds are held. No tick.
//  pause_pulse: running <= ~running. prescaler is kept, so resume continues the partial period.
//  Simultaneous pulses in one cycle: every pulse present takes effect.
//   Prescaler clear wins over a terminal-count step in that cycle: no step, no tick.
//  mode_pulse or speed_pulse while paused: applied, and the block stays paused.
//  An input held high for N cycles is treated as N pulses (the upstream block must supply pulses).
//  rst_n low mid-sequence: all state returns to reset values immediately (asynchronous).
// CONFIGURATION
//  STEP_PULSE_EN defined: adds input step_pulse (1 bit).
//   While running=0, each pulse advances exactly one pattern step, asserts tick for 1 cycle and
//   clears the prescaler. step_pulse is ignored while running=1.
//   If step_pulse and mode_pulse arrive in the same cycle, mode_pulse wins (restart, no step).
//  STEP_PULSE_EN undefined: port absent and no single-step logic.
// TESTING (CYCLES_PER_UNIT=100, SPEED_MAX=3)
//  Reset, then run 600 cycles -> ticks every 100 cycles, leds 0010,0100,1000,0100,0010,0001.
//  Pulse mode at a mid-period cycle -> next edge mode=1, leds=0001. Then 4 ticks at 100-cycle
//   spacing -> leds 0010,0100,1000,0001.
//  Pulse speed twice -> speed_units=3, ticks at 300-cycle spacing. A third pulse -> speed_units=1.
//  Pause at cycle 50 of a period, wait 1000 cycles -> no tick and leds frozen. Resume -> next tick
//   50 cycles later.
//  Mode and speed pulses in the same cycle as the terminal count -> no tick, new mode first
//   pattern, new speed. Select mode3 -> fill sequence wraps through 0000 to 0001.
//  Assert rst_n low mid-bounce -> leds=0001 and mode=0 without waiting for a clk edge.
//   With STEP_PULSE_EN, paused: 3 step pulses -> 3 ticks and 3 pattern advances.

Source files
------------

// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: pattern sequencer for the 4-LED bank.
// Takes debounced single-cycle button pulses and keeps the mode, speed and
// run/pause state. A prescaler generates step ticks. The LED pattern is
// registered, and tick is high in the cycle that leds show a new step.
// Optional feature macro: STEP_PULSE_EN adds a step_pulse input. While paused,
// each step_pulse advances the pattern by exactly one step.
module led_seq_ctrl #(
    parameter int CYCLES_PER_UNIT = 125_000_000,
    parameter int SPEED_MAX       = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mode_pulse,
    input  logic       speed_pulse,
    input  logic       pause_pulse,
`ifdef STEP_PULSE_EN
    input  logic       step_pulse,
`endif
    output logic [3:0] leds,
    output logic [1:0] mode,
    output logic [1:0] speed_units,
    output logic       running,
    output logic       tick
);

    localparam int PW = $clog2(CYCLES_PER_UNIT * SPEED_MAX);

    typedef enum logic [1:0] {
        MODE_BOUNCE = 2'd0,
        MODE_ROT_UP = 2'd1,
        MODE_ROT_DN = 2'd2,
        MODE_FILL   = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } dir_e;

    mode_e         r_mode,    w_mode_nxt;
    dir_e          r_dir,     w_dir_nxt,   w_step_dir;
    logic [1:0]    r_speed,   w_speed_nxt;
    logic          r_running, w_running_nxt;
    logic [PW-1:0] r_presc,   w_presc_nxt;
    logic [2:0]    r_pos,     w_pos_nxt,   w_step_pos;
    logic [3:0]    r_leds,    w_leds_nxt;
    logic          r_tick,    w_tick_nxt;
    int            w_limit;
    logic          w_tc;
    logic          w_step;
    logic          w_clear;

    // Map a mode and step index to the LED pattern shown at that step.
    function automatic logic [3:0] pattern(input mode_e m, input logic [2:0] p);
        case (m)
            MODE_BOUNCE,
            MODE_ROT_UP: return 4'b0001 << p[1:0];
            MODE_ROT_DN: return 4'b1000 >> p[1:0];
            MODE_FILL: begin
                case (p)
                    3'd0:    return 4'b0001;
                    3'd1:    return 4'b0011;
                    3'd2:    return 4'b0111;
                    3'd3:    return 4'b1111;
                    default: return 4'b0000;
                endcase
            end
            default: return 4'b0001;
        endcase
    endfunction

    // Compute the step index and bounce direction that one step would produce.
    always_comb begin
        // NOTE: each signal gets a default first, so no path leaves it unassigned and no latch is inferred.
        w_step_pos = r_pos;
        w_step_dir = r_dir;
        case (r_mode)
            MODE_BOUNCE: begin
                if (r_dir == DIR_UP) begin
                    w_step_pos = r_pos + 3'd1;
                    w_step_dir = (r_pos == 3'd2) ? DIR_DN : DIR_UP;
                end else begin
                    w_step_pos = r_pos - 3'd1;
                    w_step_dir = (r_pos == 3'd1) ? DIR_UP : DIR_DN;
                end
            end
            MODE_ROT_UP,
            MODE_ROT_DN: w_step_pos = {1'b0, r_pos[1:0] + 2'd1};
            MODE_FILL:   w_step_pos = (r_pos == 3'd4) ? 3'd0 : r_pos + 3'd1;
            default:     w_step_pos = r_pos;
        endcase
    end

    // Compute the next state from the pulses, terminal count and current state.
    always_comb begin
        w_mode_nxt    = r_mode;
        w_dir_nxt     = r_dir;
        w_speed_nxt   = r_speed;
        w_running_nxt = r_running;
        w_presc_nxt   = r_presc;
        w_pos_nxt     = r_pos;
        w_leds_nxt    = r_leds;
        w_tick_nxt    = 1'b0;

        w_limit = CYCLES_PER_UNIT * int'(r_speed);
        w_tc    = r_running && (int'(r_presc) == w_limit - 1);
`ifdef STEP_PULSE_EN
        w_step  = w_tc || (step_pulse && !r_running);
`else
        w_step  = w_tc;
`endif
        // A mode or speed change restarts the period and beats a step in the same cycle.
        w_clear = mode_pulse || speed_pulse;

        if (w_clear || w_step) begin
            w_presc_nxt = '0;
        end else if (r_running) begin
            w_presc_nxt = r_presc + PW'(1);
        end

        if (w_step && !w_clear) begin
            w_pos_nxt  = w_step_pos;
            w_dir_nxt  = w_step_dir;
            w_leds_nxt = pattern(r_mode, w_step_pos);
            w_tick_nxt = 1'b1;
        end

        if (mode_pulse) begin
            w_mode_nxt = mode_e'(r_mode + 2'd1);
            w_pos_nxt  = 3'd0;
            w_dir_nxt  = DIR_UP;
            w_leds_nxt = pattern(w_mode_nxt, 3'd0);
        end

        if (speed_pulse) begin
            w_speed_nxt = (r_speed == 2'(SPEED_MAX)) ? 2'd1 : r_speed + 2'd1;
        end

        if (pause_pulse) begin
            w_running_nxt = !r_running;
        end
    end

    // Register all sequencer state; reset returns to bounce at speed 1, running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode    <= MODE_BOUNCE;
            r_dir     <= DIR_UP;
            r_speed   <= 2'd1;
            r_running <= 1'b1;
            r_presc   <= '0;
            r_pos     <= 3'd0;
            r_leds    <= 4'b0001;
            r_tick    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register update from the pre-edge values.
            r_mode    <= w_mode_nxt;
            r_dir     <= w_dir_nxt;
            r_speed   <= w_speed_nxt;
            r_running <= w_running_nxt;
            r_presc   <= w_presc_nxt;
            r_pos     <= w_pos_nxt;
            r_leds    <= w_leds_nxt;
            r_tick    <= w_tick_nxt;
        end
    end

    assign leds        = r_leds;
    assign mode        = r_mode;
    assign speed_units = r_speed;
    assign running     = r_running;
    assign tick        = r_tick;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Testbench for led_seq_ctrl with CYCLES_PER_UNIT=100 and SPEED_MAX=3.
// A table of vectors checks the main run from reset. Hand-written sequences
// then cover async reset, pulses while paused and, with STEP_PULSE_EN, single-stepping.
module tb_led_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mode_pulse = 1'b0;
    logic       speed_pulse = 1'b0;
    logic       pause_pulse = 1'b0;
`ifdef STEP_PULSE_EN
    logic       step_pulse = 1'b0;
`endif
    logic [3:0] leds;
    logic [1:0] mode;
    logic [1:0] speed_units;
    logic       running;
    logic       tick;

    int n_checks = 0;
    int n_pass   = 0;
    int n_ticks  = 0;

    typedef struct {
        logic       mp;
        logic       sp;
        logic       pp;
        int         adv;
        logic [3:0] leds;
        logic [1:0] mode;
        logic [1:0] speed;
        logic       running;
        logic       tick;
        int         ticks;
    } vec_t;

    vec_t vecs[$];

    led_seq_ctrl #(
        .CYCLES_PER_UNIT(100),
        .SPEED_MAX      (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode_pulse (mode_pulse),
        .speed_pulse(speed_pulse),
        .pause_pulse(pause_pulse),
`ifdef STEP_PULSE_EN
        .step_pulse (step_pulse),
`endif
        .leds       (leds),
        .mode       (mode),
        .speed_units(speed_units),
        .running    (running),
        .tick       (tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Step n clock edges, sampling at each falling edge and counting ticks.
    task automatic advance(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (tick) n_ticks++;
        end
    endtask

    // Hold the given pulses for exactly one rising edge.
    task automatic pulse(input logic mp, input logic sp, input logic pp, input logic st);
        mode_pulse  = mp;
        speed_pulse = sp;
        pause_pulse = pp;
`ifdef STEP_PULSE_EN
        step_pulse  = st;
`endif
        advance(1);
        mode_pulse  = 1'b0;
        speed_pulse = 1'b0;
        pause_pulse = 1'b0;
`ifdef STEP_PULSE_EN
        step_pulse  = 1'b0;
`endif
        if (st && 1'b0) n_ticks = n_ticks;
    endtask

    task automatic add_vec(input logic mp, input logic sp, input logic pp, input int adv,
                           input logic [3:0] lv, input logic [1:0] md, input logic [1:0] sd,
                           input logic rn, input logic tk, input int tc);
        vec_t v;
        v.mp = mp; v.sp = sp; v.pp = pp; v.adv = adv;
        v.leds = lv; v.mode = md; v.speed = sd; v.running = rn; v.tick = tk; v.ticks = tc;
        vecs.push_back(v);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n   = 1'b1;
        n_ticks = 0;
    endtask

    initial begin
        int t0;

        // Expected run from reset, speed 1 (100 cycles per step).
        //       mp sp pp adv   leds     md sd rn tk ticks
        add_vec(0, 0, 0, 100, 4'b0010, 0, 1, 1, 1, 1);
        add_vec(0, 0, 0, 1,   4'b0010, 0, 1, 1, 0, 1);
        add_vec(0, 0, 0, 99,  4'b0100, 0, 1, 1, 1, 2);
        add_vec(0, 0, 0, 100, 4'b1000, 0, 1, 1, 1, 3);
        add_vec(0, 0, 0, 100, 4'b0100, 0, 1, 1, 1, 4);
        add_vec(0, 0, 0, 100, 4'b0010, 0, 1, 1, 1, 5);
        add_vec(0, 0, 0, 100, 4'b0001, 0, 1, 1, 1, 6);
        add_vec(0, 0, 0, 50,  4'b0001, 0, 1, 1, 0, 6);
        // Mode change mid-period: restart rotate-up.
        add_vec(1, 0, 0, 1,   4'b0001, 1, 1, 1, 0, 6);
        add_vec(0, 0, 0, 100, 4'b0010, 1, 1, 1, 1, 7);
        add_vec(0, 0, 0, 99,  4'b0010, 1, 1, 1, 0, 7);
        add_vec(0, 0, 0, 1,   4'b0100, 1, 1, 1, 1, 8);
        add_vec(0, 0, 0, 100, 4'b1000, 1, 1, 1, 1, 9);
        add_vec(0, 0, 0, 100, 4'b0001, 1, 1, 1, 1, 10);
        // Speed 1 -> 2 -> 3, then 300-cycle steps, then wrap back to 1.
        add_vec(0, 1, 0, 1,   4'b0001, 1, 2, 1, 0, 10);
        add_vec(0, 1, 0, 1,   4'b0001, 1, 3, 1, 0, 10);
        add_vec(0, 0, 0, 299, 4'b0001, 1, 3, 1, 0, 10);
        add_vec(0, 0, 0, 1,   4'b0010, 1, 3, 1, 1, 11);
        add_vec(0, 0, 0, 300, 4'b0100, 1, 3, 1, 1, 12);
        add_vec(0, 1, 0, 1,   4'b0100, 1, 1, 1, 0, 12);
        // Pause mid-period, hold, resume: the partial period completes.
        add_vec(0, 0, 0, 50,  4'b0100, 1, 1, 1, 0, 12);
        add_vec(0, 0, 1, 1,   4'b0100, 1, 1, 0, 0, 12);
        add_vec(0, 0, 0, 1000,4'b0100, 1, 1, 0, 0, 12);
        add_vec(0, 0, 1, 1,   4'b0100, 1, 1, 1, 0, 12);
        add_vec(0, 0, 0, 48,  4'b0100, 1, 1, 1, 0, 12);
        add_vec(0, 0, 0, 1,   4'b1000, 1, 1, 1, 1, 13);
        // Mode+speed pulses on the terminal-count edge: no tick.
        add_vec(0, 0, 0, 99,  4'b1000, 1, 1, 1, 0, 13);
        add_vec(1, 1, 0, 1,   4'b1000, 2, 2, 1, 0, 13);
        add_vec(1, 1, 0, 1,   4'b0001, 3, 3, 1, 0, 13);
        add_vec(0, 1, 0, 1,   4'b0001, 3, 1, 1, 0, 13);
        // Fill sequence wraps through 0000.
        add_vec(0, 0, 0, 100, 4'b0011, 3, 1, 1, 1, 14);
        add_vec(0, 0, 0, 100, 4'b0111, 3, 1, 1, 1, 15);
        add_vec(0, 0, 0, 100, 4'b1111, 3, 1, 1, 1, 16);
        add_vec(0, 0, 0, 100, 4'b0000, 3, 1, 1, 1, 17);
        add_vec(0, 0, 0, 100, 4'b0001, 3, 1, 1, 1, 18);
        add_vec(0, 0, 0, 100, 4'b0011, 3, 1, 1, 1, 19);

        // Reset state.
        repeat (3) @(negedge clk);
        release_reset();
        check("reset.leds",    32'(leds),        32'(4'b0001));
        check("reset.mode",    32'(mode),        32'd0);
        check("reset.speed",   32'(speed_units), 32'd1);
        check("reset.running", 32'(running),     32'd1);
        check("reset.tick",    32'(tick),        32'd0);

        foreach (vecs[i]) begin
            pulse(vecs[i].mp, vecs[i].sp, vecs[i].pp, 1'b0);
            advance(vecs[i].adv - 1);
            check($sformatf("v%0d.leds", i),    32'(leds),        32'(vecs[i].leds));
            check($sformatf("v%0d.mode", i),    32'(mode),        32'(vecs[i].mode));
            check($sformatf("v%0d.speed", i),   32'(speed_units), 32'(vecs[i].speed));
            check($sformatf("v%0d.running", i), 32'(running),     32'(vecs[i].running));
            check($sformatf("v%0d.tick", i),    32'(tick),        32'(vecs[i].tick));
            check($sformatf("v%0d.ticks", i),   32'(n_ticks),     32'(vecs[i].ticks));
        end

        // Async reset from fill mode: outputs return without a clock edge.
        rst_n = 1'b0;
        #1;
        check("async.leds",    32'(leds),        32'(4'b0001));
        check("async.mode",    32'(mode),        32'd0);
        check("async.speed",   32'(speed_units), 32'd1);
        check("async.running", 32'(running),     32'd1);
        check("async.tick",    32'(tick),        32'd0);
        release_reset();

        // Async reset mid-bounce.
        advance(150);
        check("bounce.leds", 32'(leds), 32'(4'b0010));
        rst_n = 1'b0;
        #1;
        check("bounce_rst.leds", 32'(leds), 32'(4'b0001));
        check("bounce_rst.mode", 32'(mode), 32'd0);
        release_reset();

        // Mode and speed pulses while paused apply and stay paused.
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        check("pause.running", 32'(running), 32'd0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check("pmode.mode",    32'(mode),    32'd1);
        check("pmode.leds",    32'(leds),    32'(4'b0001));
        check("pmode.running", 32'(running), 32'd0);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        check("pspeed.speed",   32'(speed_units), 32'd2);
        check("pspeed.running", 32'(running),     32'd0);
        t0 = n_ticks;
        advance(300);
        check("phold.ticks", 32'(n_ticks - t0), 32'd0);
        check("phold.leds",  32'(leds),         32'(4'b0001));
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        check("resume.running", 32'(running), 32'd1);
        advance(199);
        check("resume.early_tick", 32'(tick), 32'd0);
        advance(1);
        check("resume.tick", 32'(tick), 32'd1);
        check("resume.leds", 32'(leds), 32'(4'b0010));

`ifdef STEP_PULSE_EN
        // Single-stepping while paused.
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        check("spause.running", 32'(running), 32'd0);
        t0 = n_ticks;
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        check("step1.tick", 32'(tick), 32'd1);
        check("step1.leds", 32'(leds), 32'(4'b0100));
        advance(1);
        check("step1.tick_low", 32'(tick), 32'd0);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        check("step2.leds", 32'(leds), 32'(4'b1000));
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        check("step3.leds",  32'(leds),         32'(4'b0001));
        check("step.ticks",  32'(n_ticks - t0), 32'd3);
        check("step.running", 32'(running),     32'd0);
        // Step and mode together: the mode change wins.
        pulse(1'b1, 1'b0, 1'b0, 1'b1);
        check("stepmode.mode", 32'(mode), 32'd2);
        check("stepmode.leds", 32'(leds), 32'(4'b1000));
        check("stepmode.tick", 32'(tick), 32'd0);
        // Step ignored while running.
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        check("steprun.tick", 32'(tick), 32'd0);
        check("steprun.leds", 32'(leds), 32'(4'b1000));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
